// File: rtl/fadd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_pkg
//  Description : Shared constants for the round-robin shared-adder slice:
//                FP32 word width, zero word and the arbiter FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fadd_pkg;

    localparam int          FP32_W  = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Arbiter FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage : fadd_pkg
`default_nettype wire

// File: rtl/fadd_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_rr_arbiter_if
//  Description : Request/response bundle between NREQ client datapaths and
//                the shared-adder arbiter.
//                req_valid/req_ready : per-requester handshake (NREQ bits)
//                req_a/req_b         : flattened operands, lane i at [32i+:32]
//                rsp_valid/rsp_ready : common response handshake
//                rsp_id/rsp_y        : owning requester index and FP32 sum
//                master = client side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fadd_rr_arbiter_if #(
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]                  req_valid;
    logic [NREQ*fadd_pkg::FP32_W-1:0] req_a;
    logic [NREQ*fadd_pkg::FP32_W-1:0] req_b;
    logic [NREQ-1:0]                  req_ready;
    logic                             rsp_valid;
    logic [IDW-1:0]                   rsp_id;
    logic [fadd_pkg::FP32_W-1:0]      rsp_y;
    logic                             rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y
    );

endinterface : fadd_rr_arbiter_if
`default_nettype wire

// File: rtl/faddV.sv
`default_nettype none
// ============================================================================
//  Module      : faddV
//  Description : Combinational IEEE-754 single-precision adder, round to
//                nearest even, subnormal in/out, quiet-NaN 0x7FC00000 for
//                NaN operands and inf-inf.
//                a, b : operands    y : sum
//  Revision    : 1.0 - initial release
// ============================================================================
module faddV (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic        w_a_ge, w_eff_sub, w_up;
    logic [31:0] w_l, w_s;
    logic [7:0]  w_el, w_es, w_eln, w_esn, w_d, w_sh, w_maxsh;
    logic [4:0]  w_dc, w_lz;
    logic [23:0] w_ml, w_ms;
    logic [55:0] w_t;
    logic [26:0] w_ml27, w_ms27, w_n27;
    logic [27:0] w_sum;
    logic [9:0]  w_e10, w_ef;
    logic [24:0] w_mr;

    always_comb begin
        // Order by magnitude so the difference is never negative
        w_a_ge = (a[30:0] >= b[30:0]);
        w_l    = w_a_ge ? a : b;
        w_s    = w_a_ge ? b : a;
        w_el   = w_l[30:23];
        w_es   = w_s[30:23];
        w_eln  = (w_el == 8'd0) ? 8'd1 : w_el;
        w_esn  = (w_es == 8'd0) ? 8'd1 : w_es;
        w_ml   = {|w_el, w_l[22:0]};
        w_ms   = {|w_es, w_s[22:0]};

        // Align the smaller operand; everything below R folds into sticky
        w_d    = w_eln - w_esn;
        w_dc   = (w_d > 8'd31) ? 5'd31 : w_d[4:0];
        w_t    = {w_ms, 32'b0} >> w_dc;
        w_ms27 = {w_t[55:30], |w_t[29:0]};
        w_ml27 = {w_ml, 3'b000};

        w_eff_sub = w_l[31] ^ w_s[31];
        w_sum     = w_eff_sub ? ({1'b0, w_ml27} - {1'b0, w_ms27})
                              : ({1'b0, w_ml27} + {1'b0, w_ms27});

        w_lz = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (w_sum[i]) w_lz = 5'(26 - i);
        end
        // Left shift stops at exponent 1 so tiny results come out subnormal
        w_maxsh = w_eln - 8'd1;
        w_sh    = ({3'b0, w_lz} > w_maxsh) ? w_maxsh : {3'b0, w_lz};

        if (w_sum[27]) begin
            w_n27 = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_e10 = {2'b0, w_eln} + 10'd1;
        end else begin
            w_n27 = w_sum[26:0] << w_sh;
            w_e10 = {2'b0, w_eln} - {2'b0, w_sh};
        end

        // Round to nearest, ties to even
        w_up = w_n27[2] & (w_n27[1] | w_n27[0] | w_n27[3]);
        w_mr = {1'b0, w_n27[26:3]} + {24'b0, w_up};
        if (w_mr[24])      w_ef = w_e10 + 10'd1;
        else if (w_mr[23]) w_ef = w_e10;
        else               w_ef = 10'd0;

        y = {w_l[31], w_ef[7:0], w_mr[22:0]};
        if (w_ef >= 10'd255)  y = {w_l[31], 8'hFF, 23'b0};
        if (w_sum == 28'd0)   y = {w_l[31] & ~w_eff_sub, 31'b0};
        if (w_el == 8'hFF) begin
            if ((w_l[22:0] != 23'd0) || ((w_es == 8'hFF) && w_eff_sub))
                y = 32'h7FC0_0000;
            else
                y = w_l;
        end
    end

endmodule : faddV
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns a one-hot grant
//                for the first asserted req bit at or after ptr (wrapping).
//                req : request vector (NREQ)
//                ptr : highest-priority index
//                gnt : one-hot grant, all zero when req is zero
//                idx : binary index of the granted bit (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic w_found;

    // Two passes with constant indices: first the lanes at or above ptr,
    // then the wrapped lanes below it.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (i >= int'(ptr))) begin
                w_found = 1'b1;
                gnt[i]  = 1'b1;
                idx     = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                gnt[i]  = 1'b1;
                idx     = IDW'(i);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fadd_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_rr_arbiter
//  Description : Shares one faddV among NREQ requesters with round-robin
//                arbitration. Winner operands are registered, added in one
//                EXEC cycle, and the sum is held on the response channel
//                tagged with the requester index until accepted.
//                clk, rst_n : clock, async active-low reset
//                bus        : request/response bundle (slave side)
//                busy       : high whenever not IDLE
//                op_count   : accepted responses, wraps at 2^CNT_W
//  Revision    : 1.0 - initial release
// ============================================================================
module fadd_rr_arbiter
    import fadd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fadd_rr_arbiter_if.slave  bus,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam int IDW = $clog2(NREQ);

    logic [1:0]        r_state;
    logic [IDW-1:0]    r_rr_ptr;
    logic [IDW-1:0]    r_id;
    logic [FP32_W-1:0] r_a, r_b, r_y;
    logic [CNT_W-1:0]  r_op_count;

    logic [NREQ-1:0]   w_gnt;
    logic [IDW-1:0]    w_idx;
    logic              w_handshake;
    logic [FP32_W-1:0] w_sel_a, w_sel_b, w_sum;
    logic [IDW-1:0]    w_next_ptr;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (bus.req_valid),
        .ptr  (r_rr_ptr),
        .gnt  (w_gnt),
        .idx  (w_idx)
    );

    faddV u_fadd (
        .a (r_a),
        .b (r_b),
        .y (w_sum)
    );

    // Grant is only offered in IDLE; rst_n gating keeps it low while reset
    // is held even if requests are already pending.
    assign bus.req_ready = ((r_state == IDLE) && rst_n) ? w_gnt : '0;
    assign w_handshake   = |(bus.req_valid & bus.req_ready);

    assign w_sel_a    = bus.req_a[int'(w_idx)*FP32_W +: FP32_W];
    assign w_sel_b    = bus.req_b[int'(w_idx)*FP32_W +: FP32_W];
    assign w_next_ptr = (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_a        <= FP_ZERO;
            r_b        <= FP_ZERO;
            r_y        <= FP_ZERO;
            r_op_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_idx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_y     <= w_sum;
                    r_state <= RESP;
                end
                RESP: begin
                    // Priority moves past the winner only once its result
                    // has been taken, which bounds every requester's wait.
                    if (bus.rsp_ready) begin
                        r_op_count <= r_op_count + 1'b1;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_y     = r_y;
    assign busy          = (r_state != IDLE);
    assign op_count      = r_op_count;

endmodule : fadd_rr_arbiter
`default_nettype wire

// File: tb/tb_fadd_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fadd_rr_arbiter
//  Description : Directed self-checking bench for fadd_rr_arbiter (NREQ=4,
//                CNT_W=4 so the counter wrap is reachable quickly).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [3:0] op_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_cnt  = 4'd0;

    fadd_rr_arbiter_if #(.NREQ(4)) bus ();

    fadd_rr_arbiter #(
        .NREQ  (4),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on a single requester. hold>0 keeps rsp_ready low for
    // that many cycles in RESP while a neighbour requester is pending.
    task automatic do_op(input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_y,
                         input int hold, input string tag);
        int n = 0;
        bus.req_a[idx*32 +: 32] = a;
        bus.req_b[idx*32 +: 32] = b;
        bus.req_valid[idx]      = 1'b1;
        #1;
        while (bus.req_ready[idx] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, " grant"}, 32'(bus.req_ready), 32'(1 << idx));
        tick();
        bus.req_valid[idx] = 1'b0;
        check_val({tag, " exec busy"}, 32'(busy), 32'd1);
        check_val({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        if (hold > 0) begin
            bus.rsp_ready = 1'b0;
            bus.req_valid[(idx+1)%4] = 1'b1;
        end
        tick();
        check_val({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check_val({tag, " rsp_y"}, bus.rsp_y, exp_y);
        check_val({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(idx));
        for (int k = 0; k < hold; k++) begin
            tick();
            check_val({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
            check_val({tag, " hold y"}, bus.rsp_y, exp_y);
            check_val({tag, " hold id"}, 32'(bus.rsp_id), 32'(idx));
            check_val({tag, " hold ready"}, 32'(bus.req_ready), 32'd0);
            check_val({tag, " hold count"}, 32'(op_count), 32'(exp_cnt));
        end
        if (hold > 0) begin
            bus.req_valid[(idx+1)%4] = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        tick();
        exp_cnt++;
        check_val({tag, " accepted"}, 32'(bus.rsp_valid), 32'd0);
        check_val({tag, " op_count"}, 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        check_val("reset req_ready", 32'(bus.req_ready), 32'd0);
        check_val("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("reset rsp_id", 32'(bus.rsp_id), 32'd0);
        check_val("reset rsp_y", bus.rsp_y, 32'd0);
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset op_count", 32'(op_count), 32'd0);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Arithmetic through the shared adder; ptr walks 0->1->2->3->0->1
        do_op(0, 32'h3FC0_0000, 32'h4090_0000, 32'h40C0_0000, 0, "add1p5");
        do_op(1, 32'h410A_B852, 32'hC10A_B852, 32'h0000_0000, 0, "cancel0");
        do_op(2, 32'h411A_B852, 32'hC10A_B852, 32'h3F80_0000, 0, "cancel1");
        do_op(3, 32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000, 0, "mixsign");
        do_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, "double");

        // Backpressure: 3.0 + 4.0 = 7.0, held 10 cycles with req 0 pending
        do_op(3, 32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 10, "bp");
        do_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, "preptr");

        // Reset during EXEC: pointer is 1 before reset, must be 0 after
        bus.req_a[2*32 +: 32] = 32'h3F80_0000;
        bus.req_b[2*32 +: 32] = 32'h3F80_0000;
        bus.req_valid = 4'b0100;
        #1;
        check_val("rstexec grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        check_val("rstexec busy before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rstexec busy", 32'(busy), 32'd0);
        check_val("rstexec rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rstexec rsp_y", bus.rsp_y, 32'd0);
        check_val("rstexec rsp_id", 32'(bus.rsp_id), 32'd0);
        check_val("rstexec op_count", 32'(op_count), 32'd0);
        exp_cnt = 4'd0;
        tick();
        rst_n = 1'b1;
        bus.req_a[0 +: 32] = 32'h3F80_0000;
        bus.req_valid = 4'b0101;
        #1;
        check_val("rstexec ptr0", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 4'b0100;
        #1;
        check_val("rstexec req2 first", 32'(bus.req_ready), 32'h4);
        bus.req_valid = '0;
        repeat (4) tick();
        check_val("rstexec no rsp", 32'(bus.rsp_valid), 32'd0);
        check_val("rstexec count kept", 32'(op_count), 32'd0);

        // All four valid continuously from reset: order 0,1,2,3,0
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = 32'h3F80_0000;
        end
        bus.req_b = {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000};
        bus.req_valid = 4'hF;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] sums [4];
            sums = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
            #1;
            check_val("rr grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            tick();
            check_val("rr rsp_id", 32'(bus.rsp_id), 32'(k % 4));
            check_val("rr rsp_y", bus.rsp_y, sums[k % 4]);
            tick();
            exp_cnt++;
            check_val("rr op_count", 32'(op_count), 32'(exp_cnt));
        end
        bus.req_valid = '0;
        check_val("rr five ops", 32'(op_count), 32'd5);

        // Counter wrap at CNT_W=4: 11 more operations reach 16 -> 0
        for (int k = 0; k < 11; k++) begin
            do_op(2, 32'h3FC0_0000, 32'h4090_0000, 32'h40C0_0000, 0, "wrap");
            if (k == 9) check_val("wrap at 15", 32'(op_count), 32'd15);
        end
        check_val("wrap to 0", 32'(op_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fadd_rr_arbiter
`default_nettype wire
